// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks: serializer states,
// register offsets and STATUS bit positions.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_DIVISOR = 2'd2;

  localparam int STATUS_FULL_BIT   = 0;
  localparam int STATUS_EMPTY_BIT  = 1;
  localparam int STATUS_BUSY_BIT   = 2;
  localparam int STATUS_OVF_BIT    = 3;
  localparam int STATUS_COUNT_LSB  = 4;

  // The STATUS count field is only four bits wide, so larger counts clamp at 15.
  function automatic logic [3:0] sat_count(input int unsigned c);
    return (c > 15) ? 4'd15 : 4'(c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with wrap-flag pointers; shared by TX and RX.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-slave UART transmitter: register decode, TX FIFO and an 8N1
// serializer driving a registered o_uart_tx pin.
module wb_uart_tx
  import uart_pkg::*;
#(
  parameter int                   FIFO_DEPTH  = 8,
  parameter int                   DIV_WIDTH   = 16,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        o_uart_tx,
  output logic        o_irq_tx_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 bus_req;
  logic                 wr_en;
  logic [1:0]           reg_sel;
  logic [31:0]          rdata;
  logic                 ovf;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 unused_bits;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [7:0]           fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;

  uart_tx_state_t       state, state_n;
  logic [DIV_WIDTH-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [7:0]           shift, shift_n;
  logic                 tx_q, tx_n;

  assign bus_req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_en       = bus_req & wb_we_i & wb_sel_i[0];
  assign reg_sel     = wb_adr_i[3:2];
  assign fifo_push   = wr_en & (reg_sel == UART_TXDATA);
  assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:DIV_WIDTH]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wb_dat_i[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      UART_STATUS: begin
        rdata[STATUS_FULL_BIT]  = fifo_full;
        rdata[STATUS_EMPTY_BIT] = fifo_empty;
        rdata[STATUS_BUSY_BIT]  = (state != IDLE);
        rdata[STATUS_OVF_BIT]   = ovf;
        rdata[STATUS_COUNT_LSB +: 4] = sat_count(32'(fifo_count));
      end
      UART_DIVISOR: rdata[DIV_WIDTH-1:0] = divisor;
      default: rdata = '0;
    endcase
  end

  // Ack, read data and write side effects all register on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      ovf      <= 1'b0;
      divisor  <= DEFAULT_DIV;
    end else begin
      wb_ack_o <= bus_req;
      wb_dat_o <= (bus_req & ~wb_we_i) ? rdata : '0;
      if (fifo_push & fifo_full & ~fifo_pop) begin
        ovf <= 1'b1;
      end else if (wr_en & (reg_sel == UART_STATUS) & wb_dat_i[STATUS_OVF_BIT]) begin
        ovf <= 1'b0;
      end
      if (wr_en & (reg_sel == UART_DIVISOR)) divisor <= wb_dat_i[DIV_WIDTH-1:0];
    end
  end

  // tx_n reflects the current state, so the pin trails the FSM by one clock.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    fifo_pop   = 1'b0;
    tx_n       = 1'b1;
    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_n    = fifo_dout;
          baud_cnt_n = divisor;
          state_n    = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (baud_cnt == '0) begin
          baud_cnt_n = divisor;
          bit_idx_n  = 3'd0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt - DIV_WIDTH'(1);
        end
      end
      DATA: begin
        tx_n = shift[0];
        if (baud_cnt == '0) begin
          baud_cnt_n = divisor;
          shift_n    = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt - DIV_WIDTH'(1);
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (baud_cnt == '0) begin
          state_n = IDLE;
        end else begin
          baud_cnt_n = baud_cnt - DIV_WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      tx_q     <= tx_n;
    end
  end

  assign o_uart_tx      = tx_q;
  assign o_irq_tx_empty = fifo_empty & (state == IDLE);

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx: the serial line is logged every cycle and
// compared against a frame-timing model derived from the register/frame rules.
module tb_wb_uart_tx;

  localparam int DEPTH = 8;
  localparam int LOGN  = 32768;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        o_uart_tx;
  logic        o_irq_tx_empty;

  wb_uart_tx dut (
    .clk            (clk),
    .reset          (reset),
    .wb_adr_i       (wb_adr_i),
    .wb_dat_i       (wb_dat_i),
    .wb_dat_o       (wb_dat_o),
    .wb_we_i        (wb_we_i),
    .wb_sel_i       (wb_sel_i),
    .wb_stb_i       (wb_stb_i),
    .wb_cyc_i       (wb_cyc_i),
    .wb_ack_o       (wb_ack_o),
    .o_uart_tx      (o_uart_tx),
    .o_irq_tx_empty (o_irq_tx_empty)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic tx_log  [0:LOGN-1];
  logic irq_log [0:LOGN-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      tx_log[cyc]  = o_uart_tx;
      irq_log[cyc] = o_irq_tx_empty;
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model: one entry per accepted byte, with its push edge and
  // the first/last cycle its frame occupies on the wire.
  int         f_push[$];
  int         f_start[$];
  int         f_end[$];
  logic [7:0] f_data[$];
  int         div_base;
  int         div_chg_cyc;
  int         div_new;
  int         ovf_set_cyc;
  int         ovf_clr_cyc;

  function automatic int div_at(int c);
    return (div_chg_cyc >= 0 && c >= div_chg_cyc + 2) ? div_new : div_base;
  endfunction

  function automatic int frame_end(int st);
    int cur = st;
    for (int k = 0; k < 10; k++) cur += div_at(cur) + 1;
    return cur - 1;
  endfunction

  function automatic logic exp_tx(int c);
    for (int i = 0; i < f_start.size(); i++) begin
      if (c >= f_start[i] && c <= f_end[i]) begin
        int cur = f_start[i];
        for (int k = 0; k < 10; k++) begin
          int d = div_at(cur) + 1;
          if (c < cur + d) begin
            if (k == 0) return 1'b0;
            if (k == 9) return 1'b1;
            return f_data[i][k-1];
          end
          cur += d;
        end
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [7:0] exp_status(int r);
    int         cnt  = 0;
    logic       busy = 1'b0;
    logic       ovf;
    logic [3:0] c4;
    for (int i = 0; i < f_start.size(); i++) begin
      if (f_push[i] < r && f_start[i] - 1 >= r) cnt++;
      if (f_start[i] - 1 <= r - 1 && r - 1 < f_end[i]) busy = 1'b1;
    end
    ovf = (ovf_set_cyc >= 0) && (ovf_set_cyc < r) &&
          !(ovf_clr_cyc > ovf_set_cyc && ovf_clr_cyc < r);
    c4 = (cnt > 15) ? 4'd15 : 4'(cnt);
    return {c4, ovf, busy, (cnt == 0), (cnt == DEPTH)};
  endfunction

  task automatic model_reset(input int dv);
    f_push.delete();
    f_start.delete();
    f_end.delete();
    f_data.delete();
    div_base    = dv;
    div_chg_cyc = -1;
    div_new     = dv;
    ovf_set_cyc = -1;
    ovf_clr_cyc = -1;
  endtask

  task automatic model_push(input int p, input logic [7:0] b);
    int occ = 0;
    int st;
    foreach (f_start[i]) if (f_start[i] - 1 > p) occ++;
    if (occ >= DEPTH) begin
      if (ovf_set_cyc < 0 || ovf_clr_cyc > ovf_set_cyc) begin
        ovf_set_cyc = p;
        ovf_clr_cyc = -1;
      end
      return;
    end
    st = p + 2;
    if (f_end.size() > 0 && f_end[$] + 2 > st) st = f_end[$] + 2;
    f_push.push_back(p);
    f_start.push_back(st);
    f_end.push_back(frame_end(st));
    f_data.push_back(b);
  endtask

  // Bus tasks are entered and left at a falling edge, so consecutive calls
  // keep the strobe asserted continuously.
  task automatic bus_xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rdata, output int ack_cyc);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    ack_cyc  = -1;
    rdata    = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (wb_ack_o) begin
        ack_cyc = cyc;
        rdata   = wb_dat_o;
        break;
      end
    end
    @(negedge clk);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    total++;
    if (ack_cyc < 0) begin
      bad++;
      $display("[TB] FAIL bus_ack: adr=%h we=%b got no ack within 8 cycles, want ack", adr, we);
    end
  endtask

  task automatic bus_write(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           output int ack_cyc);
    logic [31:0] unused_rd;
    bus_xfer(1'b1, adr, dat, sel, unused_rd, ack_cyc);
  endtask

  task automatic bus_read(input logic [3:0] adr, output logic [31:0] rdata, output int ack_cyc);
    bus_xfer(1'b0, adr, 32'h0, 4'hF, rdata, ack_cyc);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_wave(input string name, input int from, input int to);
    int   mis = 0;
    int   first = -1;
    logic a = 1'b0;
    logic e = 1'b0;
    wait_until(to + 1);
    for (int c = from; c <= to; c++) begin
      if (tx_log[c] !== exp_tx(c)) begin
        if (first < 0) begin
          first = c;
          a = tx_log[c];
          e = exp_tx(c);
        end
        mis++;
      end
    end
    total++;
    if (mis != 0) begin
      bad++;
      $display("[TB] FAIL %s: %0d cycles differ, first at cycle %0d got %b want %b",
               name, mis, first, a, e);
    end
  endtask

  function automatic int find_val(input int from, input logic v, input int lim);
    for (int c = from; c < lim; c++) if (tx_log[c] === v) return c;
    return -1;
  endfunction

  task automatic test_reset();
    logic [31:0] rd;
    int          ack;
    int          t0;
    reset    = 1'b1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = '0;
    repeat (3) @(negedge clk);
    total++; if (o_uart_tx !== 1'b1) begin bad++; $display("[TB] FAIL rst_tx: got %b want 1", o_uart_tx); end
    total++; if (wb_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_ack: got %b want 0", wb_ack_o); end
    total++; if (wb_dat_o !== 32'h0) begin bad++; $display("[TB] FAIL rst_dat: got %h want 0", wb_dat_o); end
    total++; if (o_irq_tx_empty !== 1'b1) begin bad++; $display("[TB] FAIL rst_irq: got %b want 1", o_irq_tx_empty); end
    reset = 1'b0;
    model_reset(867);
    t0 = cyc;
    repeat (100) @(negedge clk);
    check_wave("idle_line", t0, cyc - 1);
    bus_read(4'h4, rd, ack);
    total++; if (rd !== 32'h2) begin bad++; $display("[TB] FAIL rst_status: got %h want 00000002", rd); end
    bus_read(4'h8, rd, ack);
    total++; if (rd !== 32'd867) begin bad++; $display("[TB] FAIL rst_divisor: got %0d want 867", rd); end
  endtask

  task automatic test_held_strobe();
    logic ack_seen [6];
    logic [31:0] dat_seen [6];
    int errs = 0;
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b0;
    wb_adr_i = 4'h8;
    wb_sel_i = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      ack_seen[i] = wb_ack_o;
      dat_seen[i] = wb_dat_o;
    end
    @(negedge clk);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    for (int i = 0; i < 6; i++) if (ack_seen[i] !== ((i % 2) == 0)) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("[TB] FAIL held_ack: ack pattern %b%b%b%b%b%b want 101010", ack_seen[0], ack_seen[1],
               ack_seen[2], ack_seen[3], ack_seen[4], ack_seen[5]);
    end
    errs = 0;
    for (int i = 0; i < 6; i++) if (dat_seen[i] !== (((i % 2) == 0) ? 32'd867 : 32'd0)) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("[TB] FAIL held_dat: got %h/%h want 867 on ack, 0 otherwise", dat_seen[0], dat_seen[1]);
    end
  endtask

  task automatic test_sel_and_unmapped();
    logic [31:0] rd;
    int          ack;
    int          t0;
    t0 = cyc;
    bus_write(4'h0, 32'h5A, 4'b0010, ack);
    bus_read(4'h4, rd, ack);
    total++; if (rd !== 32'h2) begin bad++; $display("[TB] FAIL sel_status: got %h want 00000002", rd); end
    bus_read(4'hC, rd, ack);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL rd_addr_c: got %h want 0", rd); end
    bus_read(4'h0, rd, ack);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL rd_txdata: got %h want 0", rd); end
    bus_write(4'hC, 32'h55, 4'hF, ack);
    bus_write(4'h8, 32'h3, 4'b0010, ack);
    bus_read(4'h8, rd, ack);
    total++; if (rd !== 32'd867) begin bad++; $display("[TB] FAIL div_untouched: got %0d want 867", rd); end
    repeat (20) @(negedge clk);
    check_wave("sel_idle_line", t0, cyc - 1);
  endtask

  task automatic test_single_frame();
    logic [31:0] rd;
    logic [7:0]  got;
    int          ack;
    int          p;
    bus_write(4'h8, 32'd3, 4'hF, ack);
    model_reset(3);
    bus_write(4'h0, 32'hA5, 4'hF, p);
    model_push(p, 8'hA5);
    wait_until(f_end[0] + 3);
    total++;
    if (tx_log[p+1] !== 1'b1 || tx_log[p+2] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL start_latency: tx at N+1,N+2 = %b%b want 10", tx_log[p+1], tx_log[p+2]);
    end
    for (int k = 0; k < 8; k++) got[k] = tx_log[p + 2 + 4 * (k + 1) + 2];
    total++; if (got !== 8'hA5) begin bad++; $display("[TB] FAIL a5_decode: got %h want a5", got); end
    check_wave("a5_wave", p, f_end[0] + 2);
    total++;
    if (irq_log[p + 12] !== 1'b0) begin bad++; $display("[TB] FAIL irq_busy: got %b want 0", irq_log[p + 12]); end
    total++;
    if (irq_log[f_end[0] + 1] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL irq_done: got %b want 1", irq_log[f_end[0] + 1]);
    end
    bus_read(4'h4, rd, ack);
    total++; if (rd[7:0] !== exp_status(ack)) begin bad++; $display("[TB] FAIL a5_status: got %h want %h", rd[7:0], exp_status(ack)); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    int          ack;
    int          p0;
    int          p;
    int          s0, o1, s1;
    bus_write(4'h8, 32'd1, 4'hF, ack);
    model_reset(1);
    for (int i = 0; i < 10; i++) begin
      bus_write(4'h0, 32'(i), 4'hF, p);
      if (i == 0) p0 = p;
      model_push(p, 8'(i));
    end
    bus_read(4'h4, rd, ack);
    total++; if (rd[7:0] !== exp_status(ack)) begin bad++; $display("[TB] FAIL ovf_status: got %h want %h", rd[7:0], exp_status(ack)); end
    total++; if (rd[3] !== 1'b1) begin bad++; $display("[TB] FAIL ovf_bit: got %b want 1", rd[3]); end
    bus_write(4'h4, 32'h8, 4'hF, ack);
    ovf_clr_cyc = ack;
    bus_read(4'h4, rd, ack);
    total++; if (rd[7:0] !== exp_status(ack)) begin bad++; $display("[TB] FAIL ovf_clear: got %h want %h", rd[7:0], exp_status(ack)); end
    wait_until(f_end[$] + 3);
    check_wave("ovf_wave", p0, f_end[$] + 2);
    s0 = find_val(p0, 1'b0, cyc);
    o1 = find_val(s0, 1'b1, cyc);
    s1 = find_val(o1, 1'b0, cyc);
    total++;
    if (s1 - s0 != 21) begin bad++; $display("[TB] FAIL frame_spacing: got %0d want 21", s1 - s0); end
  endtask

  task automatic test_divisor_change();
    int         ack;
    int         p;
    int         w;
    logic [7:0] b;
    bus_write(4'h8, 32'd3, 4'hF, ack);
    model_reset(3);
    b = 8'($urandom);
    bus_write(4'h0, {24'h0, b}, 4'hF, p);
    model_push(p, b);
    div_chg_cyc = f_start[0] + 17;
    div_new     = 7;
    f_end[0]    = frame_end(f_start[0]);
    wait_until(f_start[0] + 16);
    bus_write(4'h8, 32'd7, 4'hF, w);
    total++;
    if (w != div_chg_cyc) begin bad++; $display("[TB] FAIL div_write_time: got %0d want %0d", w, div_chg_cyc); end
    total++;
    if (f_end[0] - f_start[0] + 1 != 60) begin
      bad++;
      $display("[TB] FAIL div_frame_len: got %0d want 60", f_end[0] - f_start[0] + 1);
    end
    check_wave("div_change_wave", p, f_end[0] + 3);
  endtask

  task automatic test_random();
    logic [31:0] rd;
    int          ack;
    int          p;
    int          p_first;
    int          n;
    int          dv;
    logic [3:0]  sel;
    for (int it = 0; it < 3; it++) begin
      dv = $urandom_range(0, 3);
      bus_write(4'h8, 32'(dv), 4'hF, ack);
      model_reset(dv);
      n = $urandom_range(4, 14);
      p_first = cyc;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 40)) @(negedge clk);
        sel = ($urandom_range(0, 7) == 0) ? 4'b1110 : 4'hF;
        rd  = $urandom;
        bus_write(4'h0, rd, sel, p);
        if (sel[0]) model_push(p, rd[7:0]);
      end
      bus_read(4'h4, rd, ack);
      total++;
      if (rd[7:0] !== exp_status(ack)) begin
        bad++;
        $display("[TB] FAIL rnd_status_mid it=%0d: got %h want %h", it, rd[7:0], exp_status(ack));
      end
      if (f_end.size() > 0) begin
        wait_until(f_end[$] + 3);
        check_wave("rnd_wave", p_first, f_end[$] + 2);
      end
      bus_read(4'h4, rd, ack);
      total++;
      if (rd[7:0] !== exp_status(ack)) begin
        bad++;
        $display("[TB] FAIL rnd_status_end it=%0d: got %h want %h", it, rd[7:0], exp_status(ack));
      end
      bus_write(4'h4, 32'h8, 4'hF, ack);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    int          ack;
    int          p;
    int          t0;
    bus_write(4'h8, 32'd3, 4'hF, ack);
    model_reset(3);
    bus_write(4'h0, 32'h00, 4'hF, p);
    model_push(p, 8'h00);
    bus_write(4'h0, 32'h00, 4'hF, ack);
    model_push(ack, 8'h00);
    wait_until(f_start[0] + 6);
    total++; if (o_uart_tx !== 1'b0) begin bad++; $display("[TB] FAIL pre_reset_tx: got %b want 0", o_uart_tx); end
    #1 reset = 1'b1;
    #1;
    total++; if (o_uart_tx !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_tx: got %b want 1", o_uart_tx); end
    @(negedge clk);
    reset = 1'b0;
    model_reset(867);
    t0 = cyc;
    bus_read(4'h4, rd, ack);
    total++; if (rd !== 32'h2) begin bad++; $display("[TB] FAIL post_reset_status: got %h want 00000002", rd); end
    bus_read(4'h8, rd, ack);
    total++; if (rd !== 32'd867) begin bad++; $display("[TB] FAIL post_reset_div: got %0d want 867", rd); end
    repeat (60) @(negedge clk);
    check_wave("post_reset_idle", t0, cyc - 1);
  endtask

  initial begin
    model_reset(867);
    test_reset();
    test_held_strobe();
    test_sel_and_unmapped();
    test_single_frame();
    test_overflow();
    test_divisor_change();
    test_random();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
